// File: rtl/sayac_cache_pkg.sv
// Shared widths, derived-constant helpers and write-back FSM encoding for the sayac cache.
// The SCAN/CHECK flush states exist only when WB_FLUSH_EN is defined.
package sayac_cache_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_TAG_WIDTH    = 6;
  localparam int DEF_INDEX_WIDTH  = 8;
  localparam int DEF_OFFSET_WIDTH = 2;

  function automatic int calc_words(input int offset_width);
    return 1 << offset_width;
  endfunction

  function automatic int calc_addr_width(input int tag_width, input int index_width,
                                         input int offset_width);
    return tag_width + index_width + offset_width;
  endfunction

`ifdef WB_FLUSH_EN
  typedef enum logic [2:0] {
    IDLE, READ, CAP, WRITE, CLEAN, DONE, SCAN, CHECK
  } wb_state_e;
`else
  typedef enum logic [2:0] {
    IDLE, READ, CAP, WRITE, CLEAN, DONE
  } wb_state_e;
`endif

endpackage

// File: rtl/wb_word_counter.sv
// Word-in-line offset counter for the write-back evictor: clear, increment, last-word flag.
module wb_word_counter
  import sayac_cache_pkg::*;
#(
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    inc,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic                    last
);

  localparam int WORDS = calc_words(OFFSET_WIDTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      offset <= '0;
    end else if (clr) begin
      offset <= '0;
    end else if (inc) begin
      offset <= offset + OFFSET_WIDTH'(1);
    end
  end

  assign last = (offset == OFFSET_WIDTH'(WORDS - 1));

endmodule

// File: rtl/cache_wb_evictor.sv
// Writes one dirty cache line back to main memory word by word, then clears its dirty bit.
// Define WB_FLUSH_EN to add a whole-cache flush sweep driven from the tag memory.
module cache_wb_evictor
  import sayac_cache_pkg::*;
#(
  parameter int  DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int  TAG_WIDTH    = DEF_TAG_WIDTH,
  parameter int  INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int  OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  localparam int ADDR_WIDTH   = calc_addr_width(TAG_WIDTH, INDEX_WIDTH, OFFSET_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [INDEX_WIDTH-1:0]          victim_index,
  input  logic [TAG_WIDTH-1:0]            victim_tag,
`ifdef WB_FLUSH_EN
  input  logic                            flush,
  output logic                            tag_rd,
  output logic [INDEX_WIDTH-1:0]          tag_index,
  input  logic [TAG_WIDTH-1:0]            tag_in,
  input  logic                            tag_valid,
  input  logic                            tag_dirty,
`endif
  output logic                            busy,
  output logic                            done,
  output logic                            cd_rd,
  output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] cd_addr,
  input  logic [DATA_WIDTH-1:0]           cd_data,
  output logic                            mem_wr,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic                            mem_ready,
  output logic                            clean_wr,
  output logic [INDEX_WIDTH-1:0]          clean_index
);

  wb_state_e state, next_state;

  logic [INDEX_WIDTH-1:0]  index_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [OFFSET_WIDTH-1:0] offset;
  logic                    off_clr;
  logic                    off_inc;
  logic                    off_last;
  logic                    load_victim;
  logic                    load_data;

`ifdef WB_FLUSH_EN
  logic [INDEX_WIDTH-1:0]  scan_idx;
  logic                    flush_q;
  logic                    scan_clr;
  logic                    scan_inc;
  logic                    load_scan;
  logic                    scan_last;
`endif

  wb_word_counter #(
    .OFFSET_WIDTH(OFFSET_WIDTH)
  ) u_word_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (off_clr),
    .inc   (off_inc),
    .offset(offset),
    .last  (off_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Line identity and the word in flight; a reset mid-line simply drops them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_q <= '0;
      tag_q   <= '0;
      wdata_q <= '0;
    end else begin
      if (load_victim) begin
        index_q <= victim_index;
        tag_q   <= victim_tag;
      end
`ifdef WB_FLUSH_EN
      else if (load_scan) begin
        index_q <= scan_idx;
        tag_q   <= tag_in;
      end
`endif
      if (load_data) begin
        wdata_q <= cd_data;
      end
    end
  end

`ifdef WB_FLUSH_EN
  // flush_q remembers whether the current line belongs to a sweep, so CLEAN knows where to go.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_idx <= '0;
      flush_q  <= 1'b0;
    end else begin
      if (scan_clr) begin
        scan_idx <= '0;
        flush_q  <= 1'b1;
      end else if (scan_inc) begin
        scan_idx <= scan_idx + INDEX_WIDTH'(1);
      end
      if (load_victim) begin
        flush_q <= 1'b0;
      end
    end
  end

  assign scan_last = &scan_idx;
  assign tag_index = scan_idx;
`endif

  always_comb begin
    next_state  = state;
    cd_rd       = 1'b0;
    mem_wr      = 1'b0;
    clean_wr    = 1'b0;
    done        = 1'b0;
    off_clr     = 1'b0;
    off_inc     = 1'b0;
    load_victim = 1'b0;
    load_data   = 1'b0;
`ifdef WB_FLUSH_EN
    tag_rd      = 1'b0;
    scan_clr    = 1'b0;
    scan_inc    = 1'b0;
    load_scan   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          load_victim = 1'b1;
          off_clr     = 1'b1;
          next_state  = READ;
        end
`ifdef WB_FLUSH_EN
        else if (flush) begin
          scan_clr   = 1'b1;
          next_state = SCAN;
        end
`endif
      end
      READ: begin
        cd_rd      = 1'b1;
        next_state = CAP;
      end
      CAP: begin
        load_data  = 1'b1;
        next_state = WRITE;
      end
      WRITE: begin
        mem_wr = 1'b1;
        if (mem_ready) begin
          if (off_last) begin
            next_state = CLEAN;
          end else begin
            off_inc    = 1'b1;
            next_state = READ;
          end
        end
      end
      CLEAN: begin
        clean_wr   = 1'b1;
        next_state = DONE;
`ifdef WB_FLUSH_EN
        if (flush_q && !scan_last) begin
          scan_inc   = 1'b1;
          next_state = SCAN;
        end
`endif
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
`ifdef WB_FLUSH_EN
      SCAN: begin
        tag_rd     = 1'b1;
        next_state = CHECK;
      end
      CHECK: begin
        if (tag_valid && tag_dirty) begin
          load_scan  = 1'b1;
          off_clr    = 1'b1;
          next_state = READ;
        end else if (scan_last) begin
          next_state = DONE;
        end else begin
          scan_inc   = 1'b1;
          next_state = SCAN;
        end
      end
`endif
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign busy        = (state != IDLE);
  assign cd_addr     = {index_q, offset};
  assign mem_addr    = {tag_q, index_q, offset};
  assign mem_wdata   = wdata_q;
  assign clean_index = index_q;

endmodule

// File: tb/tb_cache_wb_evictor.sv
// Directed bench for cache_wb_evictor; the flush sweep section builds only with WB_FLUSH_EN.
module tb_cache_wb_evictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  victim_index = '0;
  logic [5:0]  victim_tag = '0;
  logic        busy, done, cd_rd, mem_wr, mem_ready, clean_wr;
  logic [9:0]  cd_addr;
  logic [15:0] cd_data = '0;
  logic [15:0] mem_addr, mem_wdata;
  logic [7:0]  clean_index;

  int n_checks = 0;
  int n_fail = 0;

  int cyc = 0;
  int start_edge = 0;
  int done_edge = 0;
  int done_cnt = 0;
  int hold_bad = 0;
  int hold_cnt = 0;
  int stall_used = 0;
  logic stall_en = 1'b0;
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic [7:0]  clean_q[$];

`ifdef WB_FLUSH_EN
  logic        p_tag_rd;
  logic [7:0]  p_tag_index;
`endif

  always #5 clk = ~clk;

  assign mem_ready = !(stall_en && mem_wr && mem_addr[1:0] == 2'd1 && stall_used < 5);

  cache_wb_evictor dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .victim_index(victim_index),
    .victim_tag  (victim_tag),
`ifdef WB_FLUSH_EN
    .flush       (1'b0),
    .tag_rd      (p_tag_rd),
    .tag_index   (p_tag_index),
    .tag_in      (6'h00),
    .tag_valid   (1'b0),
    .tag_dirty   (1'b0),
`endif
    .busy        (busy),
    .done        (done),
    .cd_rd       (cd_rd),
    .cd_addr     (cd_addr),
    .cd_data     (cd_data),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .clean_wr    (clean_wr),
    .clean_index (clean_index)
  );

  // Data-array model: each word is 0xC000 | {index, offset}, returned the cycle after cd_rd.
  always @(posedge clk) begin
    if (cd_rd) cd_data <= 16'hC000 | 16'(cd_addr);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start && !busy && rst) start_edge <= cyc;
    if (done) begin
      done_edge <= cyc;
      done_cnt  <= done_cnt + 1;
    end
    if (mem_wr && mem_ready) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (clean_wr) clean_q.push_back(clean_index);
    if (stall_en && mem_wr && mem_addr[1:0] == 2'd1 && stall_used < 5) stall_used <= stall_used + 1;
    if (mem_wr && !mem_ready) begin
      hold_cnt <= hold_cnt + 1;
      if (mem_addr != 16'h54A9 || mem_wdata != 16'hC0A9) hold_bad <= hold_bad + 1;
    end
  end

`ifdef WB_FLUSH_EN
  logic        f_start = 1'b0;
  logic        f_flush = 1'b0;
  logic [1:0]  f_victim_index = '0;
  logic [5:0]  f_victim_tag = '0;
  logic        f_busy, f_done, f_cd_rd, f_mem_wr, f_clean_wr, f_tag_rd;
  logic [3:0]  f_cd_addr;
  logic [15:0] f_cd_data = '0;
  logic [9:0]  f_mem_addr;
  logic [15:0] f_mem_wdata;
  logic [1:0]  f_clean_index, f_tag_index;
  logic [5:0]  f_tag_in = '0;
  logic        f_tag_valid = 1'b0;
  logic        f_tag_dirty = 1'b0;
  int          f_done_cnt = 0;
  logic [9:0]  f_wr_addr[$];
  logic [15:0] f_wr_data[$];
  logic [1:0]  f_clean_q[$];

  cache_wb_evictor #(.INDEX_WIDTH(2)) dut_flush (
    .clk         (clk),
    .rst         (rst),
    .start       (f_start),
    .victim_index(f_victim_index),
    .victim_tag  (f_victim_tag),
    .flush       (f_flush),
    .tag_rd      (f_tag_rd),
    .tag_index   (f_tag_index),
    .tag_in      (f_tag_in),
    .tag_valid   (f_tag_valid),
    .tag_dirty   (f_tag_dirty),
    .busy        (f_busy),
    .done        (f_done),
    .cd_rd       (f_cd_rd),
    .cd_addr     (f_cd_addr),
    .cd_data     (f_cd_data),
    .mem_wr      (f_mem_wr),
    .mem_addr    (f_mem_addr),
    .mem_wdata   (f_mem_wdata),
    .mem_ready   (1'b1),
    .clean_wr    (f_clean_wr),
    .clean_index (f_clean_index)
  );

  // Tag memory: every line valid, odd indexes dirty (1 -> tag 0x0A, 3 -> tag 0x33).
  always @(posedge clk) begin
    if (f_tag_rd) begin
      f_tag_valid <= 1'b1;
      f_tag_dirty <= f_tag_index[0];
      f_tag_in    <= (f_tag_index == 2'd1) ? 6'h0A : 6'h33;
    end
    if (f_cd_rd) f_cd_data <= 16'hB000 | 16'(f_cd_addr);
    if (f_done) f_done_cnt <= f_done_cnt + 1;
    if (f_mem_wr) begin
      f_wr_addr.push_back(f_mem_addr);
      f_wr_data.push_back(f_mem_wdata);
    end
    if (f_clean_wr) f_clean_q.push_back(f_clean_index);
  end
`endif

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] idx, input logic [5:0] tag);
    victim_index = idx;
    victim_tag   = tag;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 32'(done_cnt - base), 32'd1);
  endtask

  task automatic checkIdleZero(input string name);
    checkOutput({name, "_ctl"}, 32'({busy, done, cd_rd, mem_wr, clean_wr}), 32'd0);
    checkOutput({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({name, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    checkOutput({name, "_cd_addr"}, 32'(cd_addr), 32'd0);
    checkOutput({name, "_clean_index"}, 32'(clean_index), 32'd0);
  endtask

  initial begin
    int base_wr, base_cl, base_dn, n;

    @(negedge clk);
    checkIdleZero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Line 0x2A/0x15: mem_addr = {tag, index, offset} = 0x54A8..0x54AB.
    $display("[TB] single line writeback");
    base_wr = wr_addr.size();
    applyStimulus(8'h2A, 6'h15);
    waitDone(40);
    checkOutput("t1_writes", 32'(wr_addr.size() - base_wr), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t1_addr%0d", k), 32'(wr_addr[base_wr + k]), 32'h54A8 + 32'(k));
      checkOutput($sformatf("t1_data%0d", k), 32'(wr_data[base_wr + k]), 32'hC0A8 + 32'(k));
    end
    checkOutput("t1_clean_index", 32'(clean_q[clean_q.size() - 1]), 32'h2A);
    checkOutput("t1_latency", 32'(done_edge - start_edge), 32'd14);

    $display("[TB] memory stall on word 1");
    base_wr  = wr_addr.size();
    stall_en = 1'b1;
    applyStimulus(8'h2A, 6'h15);
    waitDone(60);
    stall_en = 1'b0;
    checkOutput("t2_latency", 32'(done_edge - start_edge), 32'd19);
    checkOutput("t2_hold_cycles", 32'(hold_cnt), 32'd5);
    checkOutput("t2_hold_unstable", 32'(hold_bad), 32'd0);
    checkOutput("t2_writes", 32'(wr_addr.size() - base_wr), 32'd4);
    checkOutput("t2_addr1", 32'(wr_addr[base_wr + 1]), 32'h54A9);
    checkOutput("t2_data1", 32'(wr_data[base_wr + 1]), 32'hC0A9);

    $display("[TB] start while busy");
    base_wr = wr_addr.size();
    base_cl = clean_q.size();
    base_dn = done_cnt;
    applyStimulus(8'h2A, 6'h15);
    repeat (3) @(negedge clk);
    applyStimulus(8'h11, 6'h3F);
    waitDone(60);
    repeat (20) @(negedge clk);
    checkOutput("t3_writes", 32'(wr_addr.size() - base_wr), 32'd4);
    checkOutput("t3_last_addr", 32'(wr_addr[wr_addr.size() - 1]), 32'h54AB);
    checkOutput("t3_cleans", 32'(clean_q.size() - base_cl), 32'd1);
    checkOutput("t3_clean_index", 32'(clean_q[clean_q.size() - 1]), 32'h2A);
    checkOutput("t3_dones", 32'(done_cnt - base_dn), 32'd1);
    checkOutput("t3_busy", 32'(busy), 32'd0);

    $display("[TB] reset during word 2");
    base_wr = wr_addr.size();
    base_cl = clean_q.size();
    applyStimulus(8'h2A, 6'h15);
    n = 0;
    while (!(mem_wr && mem_addr == 16'h54AA) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4_reach_word2", 32'(mem_wr && mem_addr == 16'h54AA), 32'd1);
    rst = 1'b0;
    #1;
    checkIdleZero("t4_async");
    @(negedge clk);
    checkIdleZero("t4_next");
    checkOutput("t4_no_clean", 32'(clean_q.size() - base_cl), 32'd0);
    checkOutput("t4_partial_writes", 32'(wr_addr.size() - base_wr), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    base_wr = wr_addr.size();
    applyStimulus(8'h07, 6'h01);
    waitDone(40);
    checkOutput("t4_latency", 32'(done_edge - start_edge), 32'd14);
    checkOutput("t4_writes", 32'(wr_addr.size() - base_wr), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t4_addr%0d", k), 32'(wr_addr[base_wr + k]), 32'h041C + 32'(k));
      checkOutput($sformatf("t4_data%0d", k), 32'(wr_data[base_wr + k]), 32'hC01C + 32'(k));
    end
    checkOutput("t4_clean_index", 32'(clean_q[clean_q.size() - 1]), 32'h07);
    checkOutput("t4_cleans", 32'(clean_q.size() - base_cl), 32'd1);

`ifdef WB_FLUSH_EN
    // Sweep with 4 sets: index 1 -> {0x0A,1,k} = 0x0A4.., index 3 -> {0x33,3,k} = 0x33C..
    $display("[TB] flush sweep");
    base_dn = f_done_cnt;
    f_flush = 1'b1;
    @(negedge clk);
    f_flush = 1'b0;
    n = 0;
    while (f_done_cnt == base_dn && n < 150) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    checkOutput("f_dones", 32'(f_done_cnt - base_dn), 32'd1);
    checkOutput("f_writes", 32'(f_wr_addr.size()), 32'd8);
    checkOutput("f_addr0", 32'(f_wr_addr[0]), 32'h0A4);
    checkOutput("f_addr3", 32'(f_wr_addr[3]), 32'h0A7);
    checkOutput("f_addr4", 32'(f_wr_addr[4]), 32'h33C);
    checkOutput("f_addr7", 32'(f_wr_addr[7]), 32'h33F);
    checkOutput("f_data4", 32'(f_wr_data[4]), 32'hB00C);
    checkOutput("f_cleans", 32'(f_clean_q.size()), 32'd2);
    checkOutput("f_clean0", 32'(f_clean_q[0]), 32'd1);
    checkOutput("f_clean1", 32'(f_clean_q[1]), 32'd3);

    $display("[TB] start and flush together");
    base_dn        = f_done_cnt;
    f_victim_index = 2'd2;
    f_victim_tag   = 6'h05;
    f_start        = 1'b1;
    f_flush        = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    f_flush = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("f2_dones", 32'(f_done_cnt - base_dn), 32'd1);
    checkOutput("f2_writes", 32'(f_wr_addr.size()), 32'd12);
    checkOutput("f2_addr0", 32'(f_wr_addr[8]), 32'h058);
    checkOutput("f2_cleans", 32'(f_clean_q.size()), 32'd3);
    checkOutput("f2_clean_index", 32'(f_clean_q[2]), 32'd2);
    checkOutput("f2_busy", 32'(f_busy), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
